fmap_stream_serializer: RTL

- Reader at the output end of a convolution-layer stream: captures the wide per-pixel result vector (CHANNEL words of DATA_WIDHT) on Valid_In.
- Buffers pixels in a small FIFO and replays them one channel word per handshake to a narrow downstream consumer (host readback or result dump) over a Valid/Ready interface.
- The layer has no backpressure, so this block absorbs bursts and flags any loss.
- It marks the last word of each feature map.

---
 rtl/fmap_stream_serializer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fmap_stream_serializer.sv
// ============================================================================
// Module   : fmap_stream_serializer
// Summary  : Buffers wide per-pixel result vectors in a small FIFO. It then
//            replays them one channel word per Valid/Ready handshake. It
//            marks the last word of each feature map and flags dropped pixels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmap_stream_serializer #(
  parameter int DATA_WIDHT = 32,
  parameter int CHANNEL    = 16,
  parameter int DEPTH      = 4,
  parameter int IMG_WIDHT  = 22,
  parameter int IMG_HEIGHT = 22
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDHT*CHANNEL-1:0] Data_In,
  input  logic                          Valid_In,
  output logic [DATA_WIDHT-1:0]         Data_Out,
  output logic                          Valid_Out,
  input  logic                          Ready_In,
  output logic [$clog2(CHANNEL)-1:0]    Channel_Idx,
  output logic                          Last_Out,
  output logic [$clog2(DEPTH):0]        Fifo_Count,
  output logic                          Overflow
);

  localparam int c_aw    = $clog2(DEPTH);
  localparam int c_cw    = $clog2(CHANNEL);
  localparam int c_cntw  = c_aw + 1;
  localparam int c_frame = IMG_WIDHT * IMG_HEIGHT;
  localparam int c_pw    = $clog2(c_frame + 1);

  localparam logic [c_cw-1:0]   c_last_ch  = c_cw'(CHANNEL - 1);
  localparam logic [c_cntw-1:0] c_full     = c_cntw'(DEPTH);
  localparam logic [c_cntw-1:0] c_one      = c_cntw'(1);
  localparam logic [c_pw-1:0]   c_last_pix = c_pw'(c_frame - 1);

  typedef enum logic [0:0] {
    EMPTY  = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [DATA_WIDHT*CHANNEL-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]               r_wr_ptr;
  logic [c_aw-1:0]               r_rd_ptr;
  logic [c_cntw-1:0]             r_count;
  logic [c_cw-1:0]               r_ch;
  logic [c_pw-1:0]               r_pix;
  logic                          r_overflow;

  logic                          w_xfer;
  logic                          w_pop;
  logic                          w_push;
  logic                          w_drop;
  logic [DATA_WIDHT*CHANNEL-1:0] w_head;

  assign Valid_Out = (r_state == STREAM);
  assign w_xfer    = Valid_Out && Ready_In;
  assign w_pop     = w_xfer && (r_ch == c_last_ch);
  // A full FIFO still accepts a pixel when the head frees its slot on this edge.
  assign w_push    = Valid_In && ((r_count != c_full) || w_pop);
  assign w_drop    = Valid_In && (r_count == c_full) && !w_pop;

  assign w_head      = r_mem[r_rd_ptr];
  assign Data_Out    = Valid_Out ? w_head[int'(r_ch)*DATA_WIDHT +: DATA_WIDHT] : '0;
  assign Channel_Idx = r_ch;
  assign Last_Out    = Valid_Out && (r_ch == c_last_ch) && (r_pix == c_last_pix);
  assign Fifo_Count  = r_count;
  assign Overflow    = r_overflow;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= Data_In;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= EMPTY;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ch       <= '0;
      r_pix      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
      if (w_xfer) begin
        if (w_pop) begin
          r_ch     <= '0;
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_pix    <= (r_pix == c_last_pix) ? '0 : r_pix + 1'b1;
        end else begin
          r_ch <= r_ch + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: begin
        if (w_push) begin
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (w_pop && !w_push && (r_count == c_one)) begin
          w_state_nxt = EMPTY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

endmodule

`default_nettype wire
